// File: rtl/ta_state_writer_pkg.sv
// Shared definitions for the TA-state write path: word/address widths,
// default memory geometry and the writer state encoding.
package ta_state_writer_pkg;

  localparam int TA_WORD_W     = 32;
  localparam int TA_ADDR_W     = 17;
  localparam int DEF_CLAUSES   = 2000;
  localparam int DEF_LA_CHUNKS = 49;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DONE
  } ta_state_e;

endpackage

// File: rtl/ta_write_counter.sv
// Clause/chunk/flat-address counter for the TA-state write side. The wrap
// rules match the read-side counter, so a word written at (clause, chunk)
// is read back from the same flat address.
module ta_write_counter
  import ta_state_writer_pkg::*;
#(
  parameter int CLAUSES   = DEF_CLAUSES,
  parameter int LA_CHUNKS = DEF_LA_CHUNKS,
  parameter int ADDR_W    = TA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_flag,
  input  logic              i_clear,
  input  logic              i_enable,
  output logic [ADDR_W-1:0] o_clause,
  output logic [ADDR_W-1:0] o_chunk,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] LAST_CLAUSE = ADDR_W'(CLAUSES - 1);
  localparam logic [ADDR_W-1:0] LAST_CHUNK  = ADDR_W'(LA_CHUNKS - 1);
  localparam logic [ADDR_W-1:0] ONE         = ADDR_W'(1);

  logic [ADDR_W-1:0] r_clause;
  logic [ADDR_W-1:0] r_chunk;
  logic [ADDR_W-1:0] r_addr;

  // Advance chunk, wrapping into the next clause; the flat address is a
  // running count so no multiplier is needed.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register update in this
    // block reading the pre-edge values, independent of statement order.
    if (rst_flag || i_clear) begin
      r_clause <= '0;
      r_chunk  <= '0;
      r_addr   <= '0;
    end else if (i_enable) begin
      if (r_chunk == LAST_CHUNK) begin
        r_chunk <= '0;
        if (r_clause == LAST_CLAUSE) begin
          r_clause <= '0;
          r_addr   <= '0;
        end else begin
          r_clause <= r_clause + ONE;
          r_addr   <= r_addr + ONE;
        end
      end else begin
        r_chunk <= r_chunk + ONE;
        r_addr  <= r_addr + ONE;
      end
    end
  end

  assign o_clause = r_clause;
  assign o_chunk  = r_chunk;
  assign o_addr   = r_addr;
  assign o_last   = (r_clause == LAST_CLAUSE) && (r_chunk == LAST_CHUNK);

endmodule

// File: rtl/ta_state_writer.sv
// TA-state writer: takes a valid/ready stream of TA-state words and writes
// them to the TA state RAM in clause-major order with a fixed one-cycle
// write latency.
module ta_state_writer
  import ta_state_writer_pkg::*;
#(
  parameter int CLAUSES    = DEF_CLAUSES,
  parameter int LA_CHUNKS  = DEF_LA_CHUNKS,
  parameter int DATA_WIDTH = TA_WORD_W,
  parameter int ADDR_WIDTH = TA_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_flag,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] wr_clause,
  output logic [ADDR_WIDTH-1:0] wr_chunk,
  output logic                  busy,
  output logic                  done
);

  ta_state_e             r_state;
  logic                  r_in_ready;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [ADDR_WIDTH-1:0] r_wr_clause;
  logic [ADDR_WIDTH-1:0] r_wr_chunk;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_clear;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] w_clause;
  logic [ADDR_WIDTH-1:0] w_chunk;
  logic [ADDR_WIDTH-1:0] w_addr;

  // Beats are only taken in LOAD; a new load restarts the counters at 0.
  assign w_accept = (r_state == ST_LOAD) && in_valid;
  assign w_clear  = (r_state == ST_IDLE) && start;

  ta_write_counter #(
    .CLAUSES   (CLAUSES),
    .LA_CHUNKS (LA_CHUNKS),
    .ADDR_W    (ADDR_WIDTH)
  ) u_counter (
    .clk      (clk),
    .rst_flag (rst_flag),
    .i_clear  (w_clear),
    .i_enable (w_accept),
    .o_clause (w_clause),
    .o_chunk  (w_chunk),
    .o_addr   (w_addr),
    .o_last   (w_last)
  );

  // Load sequencing plus the registered write port; address/data hold
  // their last value between writes.
  always_ff @(posedge clk) begin
    if (rst_flag) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_clause <= '0;
      r_wr_chunk  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_addr   <= w_addr;
        r_wr_data   <= in_data;
        r_wr_clause <= w_clause;
        r_wr_chunk  <= w_chunk;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_LOAD;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          // Abort wins over the last beat: the beat is still written but
          // the load ends without a done pulse.
          if (abort) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_accept && w_last) begin
            r_state    <= ST_FLUSH;
            r_in_ready <= 1'b0;
          end
        end
        ST_FLUSH: begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign wr_clause = r_wr_clause;
  assign wr_chunk  = r_wr_chunk;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_ta_state_writer.sv
// Bench for ta_state_writer: a small (3x2) and a larger (40x49) instance
// share one input stream. A behavioural model counts accepted words and
// derives clause/chunk/address arithmetically; the larger instance's writes
// are also captured into a RAM image and read back by clause/chunk.
module tb_ta_state_writer;

  localparam int AW    = 17;
  localparam int DW    = 32;
  localparam int S_CL  = 3;
  localparam int S_LA  = 2;
  localparam int B_CL  = 40;
  localparam int B_LA  = 49;
  localparam int B_TOT = B_CL * B_LA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_flag;
  logic          start;
  logic          abort;
  logic          in_valid;
  logic [DW-1:0] in_data;

  logic          rdy   [2];
  logic          wren  [2];
  logic [AW-1:0] waddr [2];
  logic [DW-1:0] wdata [2];
  logic [AW-1:0] wcl   [2];
  logic [AW-1:0] wch   [2];
  logic          bsy   [2];
  logic          dne   [2];

  ta_state_writer #(
    .CLAUSES(S_CL), .LA_CHUNKS(S_LA), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) u_small (
    .clk(clk), .rst_flag(rst_flag), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
    .wr_en(wren[0]), .wr_addr(waddr[0]), .wr_data(wdata[0]),
    .wr_clause(wcl[0]), .wr_chunk(wch[0]), .busy(bsy[0]), .done(dne[0])
  );

  ta_state_writer #(
    .CLAUSES(B_CL), .LA_CHUNKS(B_LA), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) u_big (
    .clk(clk), .rst_flag(rst_flag), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
    .wr_en(wren[1]), .wr_addr(waddr[1]), .wr_data(wdata[1]),
    .wr_clause(wcl[1]), .wr_chunk(wch[1]), .busy(bsy[1]), .done(dne[1])
  );

  int total = 0;
  int bad   = 0;

  // Model: words accepted since start, whether a load is open, and how
  // many cycles of the post-load tail remain (2 = last write, 1 = done).
  int            m_count [2];
  bit            m_load  [2];
  int            m_tail  [2];
  logic [AW-1:0] e_addr  [2];
  logic [AW-1:0] e_cl    [2];
  logic [AW-1:0] e_ch    [2];
  logic [DW-1:0] e_data  [2];

  logic [DW-1:0] big_words [B_TOT];
  logic [DW-1:0] big_ram   [B_TOT];
  bit            big_done_seen;

  function automatic int la_of(input int i);
    return (i == 0) ? S_LA : B_LA;
  endfunction

  function automatic int tot_of(input int i);
    return (i == 0) ? S_CL * S_LA : B_TOT;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare both instances.
  task automatic cyc(input bit st, input bit ab, input bit v, input bit rs,
                     input logic [DW-1:0] d);
    bit idle [2];
    bit acc  [2];
    bit ewr  [2];
    start    = st;
    abort    = ab;
    in_valid = v;
    rst_flag = rs;
    in_data  = d;
    for (int i = 0; i < 2; i++) begin
      idle[i] = !m_load[i] && (m_tail[i] == 0);
      acc[i]  = v && m_load[i] && !rs;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      ewr[i] = 1'b0;
      if (rs) begin
        m_load[i]  = 1'b0;
        m_tail[i]  = 0;
        m_count[i] = 0;
        e_addr[i]  = '0;
        e_cl[i]    = '0;
        e_ch[i]    = '0;
        e_data[i]  = '0;
      end else begin
        if (m_tail[i] > 0) m_tail[i]--;
        if (acc[i]) begin
          ewr[i]    = 1'b1;
          e_addr[i] = AW'(m_count[i]);
          e_cl[i]   = AW'(m_count[i] / la_of(i));
          e_ch[i]   = AW'(m_count[i] % la_of(i));
          e_data[i] = d;
          if (i == 1) big_words[m_count[i]] = d;
          m_count[i]++;
        end
        if (m_load[i] && ab) begin
          m_load[i] = 1'b0;
        end else if (acc[i] && m_count[i] == tot_of(i)) begin
          m_load[i] = 1'b0;
          m_tail[i] = 2;
        end
        if (idle[i] && st) begin
          m_load[i]  = 1'b1;
          m_count[i] = 0;
        end
      end
      check($sformatf("in_ready%0d", i), rdy[i], m_load[i]);
      check($sformatf("busy%0d", i), bsy[i], m_load[i] || m_tail[i] == 2);
      check($sformatf("done%0d", i), dne[i], m_tail[i] == 1);
      check($sformatf("wr_en%0d", i), wren[i], ewr[i]);
      check($sformatf("wr_addr%0d", i), waddr[i], e_addr[i]);
      check($sformatf("wr_clause%0d", i), wcl[i], e_cl[i]);
      check($sformatf("wr_chunk%0d", i), wch[i], e_ch[i]);
      check($sformatf("wr_data%0d", i), wdata[i], e_data[i]);
    end
    if (wren[1] === 1'b1 && int'(waddr[1]) < B_TOT) big_ram[waddr[1]] = wdata[1];
    if (dne[1] === 1'b1) big_done_seen = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      m_count[i] = 0; m_load[i] = 1'b0; m_tail[i] = 0;
      e_addr[i] = '0; e_cl[i] = '0; e_ch[i] = '0; e_data[i] = '0;
    end
    big_done_seen = 1'b0;

    // Reset, then check the idle/reset state.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    idle_cycles(2);

    // Back-to-back full load of the small instance.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hA0 + 32'(k));
    idle_cycles(3);

    // Bubbles: in_valid alternating 1,0.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 12; k++) cyc(1'b0, 1'b0, ((k % 2) == 0), 1'b0, 32'hB0 + 32'(k));
    idle_cycles(3);

    // Abort after three beats, reload, abort with a beat in the abort cycle.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hC0 + 32'(k));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle_cycles(2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hC8);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'hC9);
    idle_cycles(2);

    // Reset on the 4th beat, then a fresh start from clause 0 chunk 0.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hD0 + 32'(k));
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'hD3);
    idle_cycles(1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hD8);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hD9);

    // start during LOAD is ignored; in_valid while idle writes nothing.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'hE0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'hE1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'hE8 + 32'(k));

    // Random full load of the large instance, with read-back.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int a = 0; a < B_TOT; a++) big_ram[a] = '0;
    big_done_seen = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);
    n = 0;
    while ((m_load[1] || m_tail[1] != 0) && n < 6000) begin
      cyc(($urandom_range(0, 19) == 0), 1'b0, ($urandom_range(0, 9) < 8), 1'b0, $urandom);
      n++;
    end
    check("big_no_timeout", (n < 6000), 1'b1);
    check("big_done_seen", big_done_seen, 1'b1);
    check("big_last_addr", waddr[1], B_TOT - 1);
    check("big_last_clause", wcl[1], B_CL - 1);
    check("big_last_chunk", wch[1], B_LA - 1);
    for (int c = 0; c < B_CL; c++)
      for (int k = 0; k < B_LA; k++)
        check($sformatf("readback_c%0d_k%0d", c, k), big_ram[c * B_LA + k],
              big_words[c * B_LA + k]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
